// File: rtl/pll_supervisor_pkg.sv
// pll_supervisor_pkg
// Shared types and helpers for the PLL supervisor.
//   sup_state_e : supervisor sequencing states
//   cntWidth()  : bits needed for a counter that must hold 0..maxVal
//   maxOf()     : larger of two integers, used to size the shared timer
package pll_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } sup_state_e;

  // At least one bit, so a degenerate maximum of 0 or 1 still yields a legal vector
  function automatic int cntWidth(input int maxVal);
    return (maxVal < 2) ? 1 : $clog2(maxVal + 1);
  endfunction

  function automatic int maxOf(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchroniser for a single asynchronous level signal.
//   clk_i  : destination clock
//   rst_ni : asynchronous active-low reset, clears both flops
//   d_i    : asynchronous input level
//   q_o    : synchronised level, two clk_i cycles of latency
module sync_2ff (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_supervisor.sv
// pll_supervisor
// Brings up a PLL and sequences per-domain resets once lock is stable.
// Flow: PLL reset pulse -> wait for lock (with timeout/retry) -> lock
// stability window -> staggered domain reset release -> RUN. A lock loss
// after release drops every domain back into reset and restarts the flow.
//   clkin           : free-running board clock, the only clock used here
//   rst_n           : asynchronous active-low reset
//   pll_locked      : PLL lock indicator, asynchronous to clkin
//   force_relock    : single-cycle request to restart the whole sequence
//   pll_rst         : active-high reset to the PLL
//   domain_rst_n    : active-low domain resets, index 0 released first
//   ready           : high while in RUN
//   fault           : high while in FAULT (retries exhausted)
//   retry_count     : lock timeouts seen in the current sequence
//   lock_loss_count : lock losses while in RUN, saturating at 255
module pll_supervisor
  import pll_supervisor_pkg::*;
#(
  parameter int NUM_DOMAINS         = 3,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 25000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RELEASE_GAP_CYCLES  = 64,
  parameter int MAX_RETRIES         = 4
) (
  input  logic                               clkin,
  input  logic                               rst_n,
  input  logic                               pll_locked,
  input  logic                               force_relock,
  output logic                               pll_rst,
  output logic [NUM_DOMAINS-1:0]             domain_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
  output logic [7:0]                         lock_loss_count
);

  // One timer serves every phase, so it is sized for the longest interval
  localparam int TimerMax = maxOf(maxOf(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                  maxOf(LOCK_STABLE_CYCLES, RELEASE_GAP_CYCLES));
  localparam int TimerW   = cntWidth(TimerMax);
  localparam int RetryW   = $clog2(MAX_RETRIES + 1);

  localparam logic [TimerW-1:0]      RstLast     = TimerW'(PLL_RST_CYCLES - 1);
  localparam logic [TimerW-1:0]      TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0]      StableLast  = TimerW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TimerW-1:0]      GapLast     = TimerW'(RELEASE_GAP_CYCLES - 1);
  localparam logic [TimerW-1:0]      TimerOne    = TimerW'(1);
  localparam logic [RetryW-1:0]      RetryMax    = RetryW'(MAX_RETRIES);
  localparam logic [RetryW-1:0]      RetryOne    = RetryW'(1);
  localparam logic [NUM_DOMAINS-1:0] DomFirst    = NUM_DOMAINS'(1);

  sup_state_e              state_q;
  logic [TimerW-1:0]       timer_q;
  logic                    pllRst_q;
  logic [NUM_DOMAINS-1:0]  dom_q;
  logic                    ready_q;
  logic                    fault_q;
  logic [RetryW-1:0]       retry_q;
  logic [7:0]              lossCnt_q;
  logic                    lockSync;

  sync_2ff u_lock_sync (
    .clk_i  (clkin),
    .rst_ni (rst_n),
    .d_i    (pll_locked),
    .q_o    (lockSync)
  );

  // Sequencer. All outputs are registered here so domain resets never glitch.
  // domain_rst_n is a thermometer code: released domains are shifted in from
  // bit 0 upwards and every domain is cleared together on any restart.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_PLL_RST;
      timer_q   <= '0;
      pllRst_q  <= 1'b1;
      dom_q     <= '0;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= '0;
      lossCnt_q <= '0;
    end else if (force_relock) begin
      // A lock loss coinciding with the request is still recorded
      if (state_q == ST_RUN && !lockSync && lossCnt_q != 8'hFF) begin
        lossCnt_q <= lossCnt_q + 8'd1;
      end
      state_q  <= ST_PLL_RST;
      timer_q  <= '0;
      pllRst_q <= 1'b1;
      dom_q    <= '0;
      ready_q  <= 1'b0;
      fault_q  <= 1'b0;
      retry_q  <= '0;
    end else begin
      case (state_q)
        ST_PLL_RST: begin
          if (timer_q == RstLast) begin
            state_q  <= ST_WAIT_LOCK;
            timer_q  <= '0;
            pllRst_q <= 1'b0;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        ST_WAIT_LOCK: begin
          if (lockSync) begin
            state_q <= ST_STABLE;
            timer_q <= '0;
          end else if (timer_q == TimeoutLast) begin
            timer_q  <= '0;
            pllRst_q <= 1'b1;
            if (retry_q == RetryMax) begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end else begin
              state_q <= ST_PLL_RST;
              retry_q <= retry_q + RetryOne;
            end
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        ST_STABLE: begin
          if (!lockSync) begin
            state_q <= ST_WAIT_LOCK;
            timer_q <= '0;
          end else if (timer_q == StableLast) begin
            state_q <= ST_RELEASE;
            timer_q <= '0;
            dom_q   <= DomFirst;
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        ST_RELEASE: begin
          if (!lockSync) begin
            state_q  <= ST_PLL_RST;
            timer_q  <= '0;
            pllRst_q <= 1'b1;
            dom_q    <= '0;
          end else if (timer_q == GapLast) begin
            timer_q <= '0;
            if (dom_q[NUM_DOMAINS-1]) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
              retry_q <= '0;
            end else begin
              dom_q <= (dom_q << 1) | DomFirst;
            end
          end else begin
            timer_q <= timer_q + TimerOne;
          end
        end

        ST_RUN: begin
          if (!lockSync) begin
            state_q  <= ST_PLL_RST;
            timer_q  <= '0;
            pllRst_q <= 1'b1;
            dom_q    <= '0;
            ready_q  <= 1'b0;
            if (lossCnt_q != 8'hFF) begin
              lossCnt_q <= lossCnt_q + 8'd1;
            end
          end
        end

        ST_FAULT: begin
          // Parked with the PLL held in reset until rst_n or force_relock
        end

        default: begin
          state_q  <= ST_PLL_RST;
          timer_q  <= '0;
          pllRst_q <= 1'b1;
          dom_q    <= '0;
          ready_q  <= 1'b0;
          fault_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst         = pllRst_q;
  assign domain_rst_n    = dom_q;
  assign ready           = ready_q;
  assign fault           = fault_q;
  assign retry_count     = retry_q;
  assign lock_loss_count = lossCnt_q;

endmodule

// File: doc/pll_supervisor.md
PLL_SUPERVISOR -- requirements
Module: pll_supervisor

Interface
REQ-001 Parameter NUM_DOMAINS, default 3: number of sequenced reset outputs, range 1..16.
REQ-002 Parameter PLL_RST_CYCLES, default 16: clkin cycles pll_rst held high per attempt.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 25000: max cycles waiting for lock per attempt.
REQ-004 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synced-lock-high cycles required before release.
REQ-005 Parameter RELEASE_GAP_CYCLES, default 64: cycles between successive domain reset releases.
REQ-006 Parameter MAX_RETRIES, default 4: lock timeouts tolerated before fault.
REQ-007 clkin  in  1  free-running 25 MHz board clock, sole clock of the block.
REQ-008 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-009 pll_locked  in  1  PLL LOCK output, asynchronous to clkin.
REQ-010 force_relock  in  1  single-cycle request to restart the full sequence.
REQ-011 pll_rst  out  1  active-high reset to PLL RST pin.
REQ-012 domain_rst_n  out  NUM_DOMAINS  per-domain active-low resets, index 0 released first.
REQ-013 ready  out  1  high only in RUN.
REQ-014 fault  out  1  high only in FAULT.
REQ-015 retry_count  out  $clog2(MAX_RETRIES+1)  lock timeouts in current sequence.
REQ-016 lock_loss_count  out  8  lock losses while in RUN, saturating at 255.

Function
REQ-017 pll_locked SHALL pass a 2-flop synchroniser; all decisions use the synced value (2-cycle latency).
REQ-018 States SHALL be PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAULT.
REQ-019 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then WAIT_LOCK.
REQ-020 WAIT_LOCK: synced lock high -> STABLE; LOCK_TIMEOUT_CYCLES elapsed without lock -> retry_count+1 and PLL_RST, or FAULT if retry_count already equals MAX_RETRIES.
REQ-021 STABLE: synced lock low on any cycle -> WAIT_LOCK with stable counter cleared (timeout counter restarts, no retry increment); LOCK_STABLE_CYCLES consecutive high -> RELEASE.
REQ-022 RELEASE: domain 0 deasserted on first RELEASE cycle; domain k deasserted RELEASE_GAP_CYCLES after domain k-1; RUN entered RELEASE_GAP_CYCLES after last domain.
REQ-023 RELEASE with synced lock low: all domain_rst_n reasserted same cycle, go to PLL_RST, no retry increment.
REQ-024 RUN: ready=1, retry_count cleared on entry; synced lock low -> all domain_rst_n=0 and ready=0 in the next cycle, lock_loss_count+1 (saturating), go to PLL_RST.
REQ-025 FAULT: pll_rst=1, all domain_rst_n=0, fault=1; exit only via rst_n or force_relock.
REQ-026 force_relock in any state: next state PLL_RST, all domain_rst_n=0, retry_count=0; coincident lock loss in RUN still increments lock_loss_count.
REQ-027 domain_rst_n SHALL deassert in ascending index order and assert simultaneously; outputs are registered, glitch-free.
REQ-028 Consumers resynchronise domain_rst_n deassertion into their own clocks; not done here.

Reset
REQ-029 rst_n low: state PLL_RST, pll_rst=1, domain_rst_n all 0, ready=0, fault=0, retry_count=0, lock_loss_count=0, synchroniser flops 0, all counters 0.
REQ-030 After rst_n deasserts, the PLL_RST_CYCLES count starts on the first clkin edge.

Structure
REQ-031 Package pll_supervisor_pkg SHALL hold the state enum and a counter-width helper function.
REQ-032 Sub-module sync_2ff SHALL implement the lock synchroniser; single shared timer counter sized for the largest cycle parameter.

Verification (NUM_DOMAINS=3, PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=16, RELEASE_GAP_CYCLES=8, MAX_RETRIES=3)
REQ-033 Lock rises 10 cycles after reset release -> pll_rst high 4 cycles; domains 0/1/2 release 8 apart; ready rises 8 after domain 2.
REQ-034 Lock never rises -> retry_count 1,2,3; fourth timeout -> fault=1, pll_rst=1, domains held in reset.
REQ-035 Lock glitches low 1 cycle during STABLE at count 10 -> back to WAIT_LOCK, full 16-cycle stability required again, retry_count unchanged.
REQ-036 Lock drops in RUN -> all domain_rst_n low next cycle, lock_loss_count=1, new PLL_RST pulse of 4 cycles.
REQ-037 force_relock in FAULT -> fault=0, retry_count=0, PLL_RST entered; rst_n asserted mid-RELEASE -> all outputs immediately at reset values.
